// File: rtl/cmb_stream_detector.sv
// cmb_stream_detector: two-stage pipelined pattern detector with hit statistics.
// Stage 1 captures the incoming word, stage 2 registers the pattern flags and
// updates the hit counters on the same edge, so statistics line up with out_valid.
module cmb_stream_detector #(
  parameter int W          = 16,
  parameter int CNT_W      = 8,
  parameter int RUN_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  input  logic [W-1:0]     in_mask,
  input  logic [1:0]       mode,
  output logic             out_valid,
  output logic             out_ones,
  output logic             out_zero,
  output logic             out_thermo,
  output logic             out_hit,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] run_len,
  output logic             run_alarm,
  output logic             sticky_hit
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] Thresh = CNT_W'(RUN_THRESH);

  logic             r_s1Valid;
  logic [W-1:0]     r_s1Data;
  logic [W-1:0]     r_s1Mask;
  logic [1:0]       r_s1Mode;

  logic             r_outValid;
  logic             r_outOnes;
  logic             r_outZero;
  logic             r_outThermo;
  logic             r_outHit;
  logic [CNT_W-1:0] r_hitCount;
  logic [CNT_W-1:0] r_runLen;
  logic             r_sticky;

  logic             w_ones;
  logic             w_zero;
  logic             w_thermo;
  logic             w_hit;
  logic [W-2:0]     w_rise;

  // A rising edge between neighbours (0 below, 1 above) breaks a thermometer code
  // only when both bits participate.
  assign w_rise   = ~r_s1Data[W-2:0] & r_s1Data[W-1:1] & r_s1Mask[W-2:0] & r_s1Mask[W-1:1];
  assign w_ones   = &(r_s1Data | ~r_s1Mask);
  assign w_zero   = ~|(r_s1Data & r_s1Mask);
  assign w_thermo = ~|w_rise;

  // Pick the flag that counts as a hit, using the mode captured with this word.
  always_comb begin
    w_hit = 1'b0;
    case (r_s1Mode)
      2'b00:   w_hit = w_ones;
      2'b01:   w_hit = w_zero;
      2'b10:   w_hit = w_thermo;
      default: w_hit = w_ones | w_zero;
    endcase
  end

  // Stage 1: capture the incoming word every cycle, whether or not it is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Data  <= '0;
      r_s1Mask  <= '0;
      r_s1Mode  <= 2'b00;
    end else begin
      r_s1Valid <= in_valid;
      r_s1Data  <= in_data;
      r_s1Mask  <= in_mask;
      r_s1Mode  <= mode;
    end
  end

  // Stage 2: flags load only for valid words and hold across bubbles; hit is gated by valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid  <= 1'b0;
      r_outOnes   <= 1'b0;
      r_outZero   <= 1'b0;
      r_outThermo <= 1'b0;
      r_outHit    <= 1'b0;
    end else begin
      r_outValid <= r_s1Valid;
      r_outHit   <= r_s1Valid & w_hit;
      if (r_s1Valid) begin
        r_outOnes   <= w_ones;
        r_outZero   <= w_zero;
        r_outThermo <= w_thermo;
      end
    end
  end

  // Hit statistics: clr wins over a simultaneous hit, bubbles leave everything untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hitCount <= '0;
      r_runLen   <= '0;
      r_sticky   <= 1'b0;
    end else if (clr) begin
      r_hitCount <= '0;
      r_runLen   <= '0;
      r_sticky   <= 1'b0;
    end else if (r_s1Valid) begin
      if (w_hit) begin
        if (r_hitCount != CntMax) r_hitCount <= r_hitCount + CNT_W'(1);
        if (r_runLen != CntMax)   r_runLen   <= r_runLen + CNT_W'(1);
        r_sticky <= 1'b1;
      end else begin
        r_runLen <= '0;
      end
    end
  end

  assign out_valid  = r_outValid;
  assign out_ones   = r_outOnes;
  assign out_zero   = r_outZero;
  assign out_thermo = r_outThermo;
  assign out_hit    = r_outHit;
  assign hit_count  = r_hitCount;
  assign run_len    = r_runLen;
  assign sticky_hit = r_sticky;
  assign run_alarm  = (r_runLen >= Thresh);

endmodule

// File: tb/tb_cmb_stream_detector.sv
// Testbench for cmb_stream_detector: directed words, literal spot checks and a
// bit-level reference model compared against two instances (CNT_W=8 and CNT_W=3).
module tb_cmb_stream_detector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [15:0] in_mask = '0;
  logic [1:0]  mode = 2'b00;

  logic        out_valid, out_ones, out_zero, out_thermo, out_hit, run_alarm, sticky_hit;
  logic [7:0]  hit_count, run_len;

  logic        v3, ones3, zero3, thermo3, hit3, alarm3, sticky3;
  logic [2:0]  hc3, rl3;

  int checks = 0;
  int errors = 0;

  cmb_stream_detector #(.W(16), .CNT_W(8), .RUN_THRESH(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_mask(in_mask), .mode(mode), .out_valid(out_valid), .out_ones(out_ones),
    .out_zero(out_zero), .out_thermo(out_thermo), .out_hit(out_hit),
    .hit_count(hit_count), .run_len(run_len), .run_alarm(run_alarm),
    .sticky_hit(sticky_hit)
  );

  cmb_stream_detector #(.W(16), .CNT_W(3), .RUN_THRESH(4)) dut3 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_mask(in_mask), .mode(mode), .out_valid(v3), .out_ones(ones3),
    .out_zero(zero3), .out_thermo(thermo3), .out_hit(hit3),
    .hit_count(hc3), .run_len(rl3), .run_alarm(alarm3),
    .sticky_hit(sticky3)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; returns after the next rising edge captured them.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic [15:0] m,
                               input logic [1:0] md, input logic c);
    in_valid = v;
    in_data  = d;
    in_mask  = m;
    mode     = md;
    clr      = c;
    @(negedge clk);
  endtask

  function automatic void patternFlags(input logic [15:0] d, input logic [15:0] m,
                                       output bit o, output bit z, output bit t);
    o = 1'b1;
    z = 1'b1;
    t = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (m[i] && !d[i]) o = 1'b0;
      if (m[i] && d[i])  z = 1'b0;
    end
    for (int i = 0; i < 15; i++)
      if (m[i] && m[i+1] && !d[i] && d[i+1]) t = 1'b0;
  endfunction

  // Reference model: each word's results appear one edge after it was captured;
  // counters are plain saturating integers. Compared every cycle, 1 unit after the edge.
  initial begin
    bit          pValid;
    logic [15:0] pData, pMask;
    logic [1:0]  pMode;
    bit          eValid, eOnes, eZero, eThermo, eHit, eSticky;
    bit          o, z, t, sel;
    int          eHc8, eRl8, eHc3, eRl3;
    pValid = 0; pData = '0; pMask = '0; pMode = 2'b00;
    eValid = 0; eOnes = 0; eZero = 0; eThermo = 0; eHit = 0; eSticky = 0;
    eHc8 = 0; eRl8 = 0; eHc3 = 0; eRl3 = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        pValid = 0;
        eValid = 0; eOnes = 0; eZero = 0; eThermo = 0; eHit = 0; eSticky = 0;
        eHc8 = 0; eRl8 = 0; eHc3 = 0; eRl3 = 0;
      end else begin
        sel = 1'b0;
        if (pValid) begin
          patternFlags(pData, pMask, o, z, t);
          eOnes = o; eZero = z; eThermo = t;
          case (pMode)
            2'b00:   sel = o;
            2'b01:   sel = z;
            2'b10:   sel = t;
            default: sel = o | z;
          endcase
        end
        eValid = pValid;
        eHit   = pValid && sel;
        if (clr) begin
          eHc8 = 0; eRl8 = 0; eHc3 = 0; eRl3 = 0; eSticky = 0;
        end else if (pValid) begin
          if (sel) begin
            eHc8 = (eHc8 < 255) ? eHc8 + 1 : 255;
            eRl8 = (eRl8 < 255) ? eRl8 + 1 : 255;
            eHc3 = (eHc3 < 7) ? eHc3 + 1 : 7;
            eRl3 = (eRl3 < 7) ? eRl3 + 1 : 7;
            eSticky = 1;
          end else begin
            eRl8 = 0; eRl3 = 0;
          end
        end
        pValid = in_valid; pData = in_data; pMask = in_mask; pMode = mode;
      end
      #1;
      checkOutput("m_valid",  out_valid,  int'(eValid));
      checkOutput("m_ones",   out_ones,   int'(eOnes));
      checkOutput("m_zero",   out_zero,   int'(eZero));
      checkOutput("m_thermo", out_thermo, int'(eThermo));
      checkOutput("m_hit",    out_hit,    int'(eHit));
      checkOutput("m_hc",     hit_count,  eHc8);
      checkOutput("m_rl",     run_len,    eRl8);
      checkOutput("m_alarm",  run_alarm,  int'(eRl8 >= 4));
      checkOutput("m_sticky", sticky_hit, int'(eSticky));
      checkOutput("m3_valid", v3,         int'(eValid));
      checkOutput("m3_hit",   hit3,       int'(eHit));
      checkOutput("m3_hc",    hc3,        eHc3);
      checkOutput("m3_rl",    rl3,        eRl3);
      checkOutput("m3_alarm", alarm3,     int'(eRl3 >= 4));
      checkOutput("m3_sticky", sticky3,   int'(eSticky));
    end
  end

  // Directed sequence with hand-computed expectations.
  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_valid",  out_valid,  0);
    checkOutput("rst_ones",   out_ones,   0);
    checkOutput("rst_zero",   out_zero,   0);
    checkOutput("rst_thermo", out_thermo, 0);
    checkOutput("rst_hc",     hit_count,  0);
    checkOutput("rst_sticky", sticky_hit, 0);

    // Flag patterns, each word followed by a bubble so its result is on the outputs.
    applyStimulus(1, 16'hFFFF, 16'hFFFF, 2'b00, 0);
    applyStimulus(0, 16'h0000, 16'h0000, 2'b00, 0);
    checkOutput("ffff_valid", out_valid, 1);
    checkOutput("ffff_ones", out_ones, 1);
    checkOutput("ffff_zero", out_zero, 0);
    checkOutput("ffff_thermo", out_thermo, 1);
    checkOutput("ffff_hit", out_hit, 1);

    applyStimulus(1, 16'h0000, 16'hFFFF, 2'b01, 0);
    applyStimulus(0, 16'h0000, 16'h0000, 2'b00, 0);
    checkOutput("0000_ones", out_ones, 0);
    checkOutput("0000_zero", out_zero, 1);
    checkOutput("0000_thermo", out_thermo, 1);
    checkOutput("0000_hit", out_hit, 1);

    applyStimulus(1, 16'h00FF, 16'hFFFF, 2'b10, 0);
    applyStimulus(0, 16'h0000, 16'h0000, 2'b00, 0);
    checkOutput("00ff_thermo", out_thermo, 1);
    checkOutput("00ff_hit", out_hit, 1);
    checkOutput("00ff_ones", out_ones, 0);

    applyStimulus(1, 16'h0102, 16'hFFFF, 2'b10, 0);
    applyStimulus(0, 16'h0000, 16'h0000, 2'b00, 0);
    checkOutput("0102_thermo", out_thermo, 0);
    checkOutput("0102_hit", out_hit, 0);

    applyStimulus(1, 16'hF0FF, 16'h00FF, 2'b00, 0);
    applyStimulus(0, 16'h0000, 16'h0000, 2'b00, 0);
    checkOutput("mask_ones", out_ones, 1);
    checkOutput("mask_thermo", out_thermo, 1);
    checkOutput("mask_zero", out_zero, 0);

    applyStimulus(1, 16'h1234, 16'h0000, 2'b11, 0);
    applyStimulus(0, 16'h0000, 16'h0000, 2'b00, 0);
    checkOutput("nomask_ones", out_ones, 1);
    checkOutput("nomask_zero", out_zero, 1);
    checkOutput("nomask_thermo", out_thermo, 1);
    checkOutput("nomask_hit", out_hit, 1);

    applyStimulus(1, 16'h0102, 16'hFFFF, 2'b11, 0);
    applyStimulus(0, 16'h0000, 16'h0000, 2'b00, 0);
    checkOutput("or_miss_hit", out_hit, 0);
    applyStimulus(0, 16'h0000, 16'h0000, 2'b00, 0);
    checkOutput("bubble_valid", out_valid, 0);
    checkOutput("bubble_hit", out_hit, 0);
    checkOutput("bubble_hold_thermo", out_thermo, 0);

    // Asynchronous reset with two words in flight.
    applyStimulus(1, 16'hFFFF, 16'hFFFF, 2'b00, 0);
    applyStimulus(1, 16'hFFFF, 16'hFFFF, 2'b00, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", out_valid, 0);
    checkOutput("arst_ones", out_ones, 0);
    checkOutput("arst_hit", out_hit, 0);
    checkOutput("arst_hc", hit_count, 0);
    checkOutput("arst_sticky", sticky_hit, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 16'hFFFF, 16'hFFFF, 2'b00, 0);
    checkOutput("post_rst_lat1", out_valid, 0);
    applyStimulus(0, 16'h0000, 16'h0000, 2'b00, 0);
    checkOutput("post_rst_lat2", out_valid, 1);
    checkOutput("post_rst_hc", hit_count, 1);

    // Run of five hits with a bubble after the second, then a miss.
    applyStimulus(0, 16'h0000, 16'h0000, 2'b00, 1);
    applyStimulus(0, 16'h0000, 16'h0000, 2'b00, 0);
    checkOutput("run_clr_hc", hit_count, 0);
    applyStimulus(1, 16'hFFFF, 16'hFFFF, 2'b00, 0);
    applyStimulus(1, 16'hFFFF, 16'hFFFF, 2'b00, 0);
    checkOutput("run_rl1", run_len, 1);
    applyStimulus(0, 16'h0000, 16'h0000, 2'b00, 0);
    checkOutput("run_rl2", run_len, 2);
    applyStimulus(1, 16'hFFFF, 16'hFFFF, 2'b00, 0);
    checkOutput("run_rl2_bubble", run_len, 2);
    applyStimulus(1, 16'hFFFF, 16'hFFFF, 2'b00, 0);
    checkOutput("run_rl3", run_len, 3);
    checkOutput("run_alarm3", run_alarm, 0);
    applyStimulus(1, 16'hFFFF, 16'hFFFF, 2'b00, 0);
    checkOutput("run_rl4", run_len, 4);
    checkOutput("run_alarm4", run_alarm, 1);
    applyStimulus(1, 16'h0000, 16'hFFFF, 2'b00, 0);
    checkOutput("run_rl5", run_len, 5);
    checkOutput("run_hc5", hit_count, 5);
    checkOutput("run_sticky", sticky_hit, 1);
    applyStimulus(0, 16'h0000, 16'h0000, 2'b00, 0);
    checkOutput("miss_rl", run_len, 0);
    checkOutput("miss_alarm", run_alarm, 0);
    checkOutput("miss_hc", hit_count, 5);

    // Saturation: ten consecutive hits.
    applyStimulus(0, 16'h0000, 16'h0000, 2'b00, 1);
    for (int k = 0; k < 10; k++) applyStimulus(1, 16'hFFFF, 16'hFFFF, 2'b00, 0);
    applyStimulus(0, 16'h0000, 16'h0000, 2'b00, 0);
    checkOutput("sat3_hc", hc3, 7);
    checkOutput("sat3_rl", rl3, 7);
    checkOutput("sat8_hc", hit_count, 10);
    checkOutput("sat8_rl", run_len, 10);

    // clr coinciding with a hit reaching the counters.
    applyStimulus(1, 16'hFFFF, 16'hFFFF, 2'b00, 0);
    applyStimulus(0, 16'h0000, 16'h0000, 2'b00, 1);
    checkOutput("clr_out_hit", out_hit, 1);
    checkOutput("clr_hc", hit_count, 0);
    checkOutput("clr_rl", run_len, 0);
    checkOutput("clr_sticky", sticky_hit, 0);
    checkOutput("clr_alarm", run_alarm, 0);
    applyStimulus(1, 16'hFFFF, 16'hFFFF, 2'b00, 0);
    applyStimulus(0, 16'h0000, 16'h0000, 2'b00, 0);
    checkOutput("after_clr_hc", hit_count, 1);
    checkOutput("after_clr_rl", run_len, 1);
    checkOutput("after_clr_sticky", sticky_hit, 1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmb_stream_detector.md
Name: cmb_stream_detector

Overview:
- Parametrised, pipelined successor to the fixed 16-input combinational pattern detector.
- Accepts a W-bit word per valid cycle, with a per-bit mask. Computes three pattern flags: masked all-ones, masked all-zero, and thermometer-code validity.
- Selects one flag as a "hit" by mode. Tracks hit statistics: a saturating hit count, a consecutive-run length, a run alarm and a sticky flag.
- Sits between a word source and the status/control register file.

Parameters:
W, 16, data/mask width (>=2)
CNT_W, 8, width of hit_count and run_len counters
RUN_THRESH, 4, run_len value at or above which run_alarm asserts (1..2^CNT_W-1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
clr  input  1  synchronous clear of counters and sticky flag
in_valid  input  1  in_data/in_mask/mode valid this cycle
in_data  input  W  word under test
in_mask  input  W  1 = bit participates, 0 = don't care
mode  input  2  hit select: 00 ones, 01 zero, 10 thermo, 11 ones|zero
out_valid  output  1  result flags valid
out_ones  output  1  all unmasked-in bits are 1
out_zero  output  1  all unmasked-in bits are 0
out_thermo  output  1  no masked rising transition
out_hit  output  1  flag selected by mode
hit_count  output  CNT_W  saturating count of hits
run_len  output  CNT_W  saturating consecutive-hit count
run_alarm  output  1  run_len >= RUN_THRESH
sticky_hit  output  1  set on any hit, cleared by clr

Behaviour:
- Reset (rst=1, asynchronous): every output and internal register is 0, including out_valid, flags, counters and sticky_hit. Reset mid-pipeline discards in-flight words.
- Stage 1, cycle N: register in_valid, in_data, in_mask and mode unconditionally. Data and mask are don't-care when in_valid=0.
- Stage 2, cycle N+1: register the flags. out_valid=1 exactly 2 clocks after in_valid=1, with no stalls and no backpressure.
  - out_ones = AND over i of (d[i] | ~m[i]).
  - out_zero = ~OR over i of (d[i] & m[i]).
  - out_thermo = ~OR over i=0..W-2 of (~d[i] & d[i+1] & m[i] & m[i+1]).
  - out_hit per the registered mode. out_hit is forced to 0 when out_valid=0.
  - Flags hold their last values when out_valid=0.
- All-zero mask: out_ones=1, out_zero=1, out_thermo=1.
- Counters update on the same edge that loads stage 2, so they are visible together with the corresponding out_valid.
  - Valid hit: hit_count += 1, saturating at 2^CNT_W-1. run_len += 1, saturating. sticky_hit <= 1.
  - Valid non-hit: run_len <= 0. hit_count and sticky_hit hold.
  - Bubble (no valid): all counters hold. Bubbles do not break a run.
- clr: on the next edge hit_count, run_len and sticky_hit go to 0.
  - clr has priority over a simultaneous hit; that hit is not counted.
  - clr does not affect the pipeline or the flag outputs.
- run_alarm is combinational from registered run_len: (run_len >= RUN_THRESH). It drops the same cycle run_len clears.
- mode changes take effect per word; each word uses the mode sampled with it.

Test Plan:
- Reset: assert rst asynchronously mid-stream with valid words in flight -> all outputs 0 immediately. First out_valid appears 2 cycles after the first post-reset in_valid.
- Flags (W=16, mask=16'hFFFF): data=16'hFFFF -> ones=1, zero=0, thermo=1. data=16'h0000 -> ones=0, zero=1, thermo=1. data=16'h00FF -> thermo=1. data=16'h0102 -> thermo=0.
- Masking: data=16'hF0FF, mask=16'h00FF -> ones=1, thermo=1. mask=16'h0000 -> all three flags 1.
- Runs: mode=00, RUN_THRESH=4, five all-ones words with a bubble after the second.
  - Expected: run_len 1,2,2,3,4,5; run_alarm at run_len=4; hit_count=5; sticky_hit=1.
  - Then a non-hit word -> run_len=0, alarm=0, hit_count=5.
- Saturation: CNT_W=3 with 10 consecutive hits -> hit_count and run_len stick at 7.
- clr: clr together with a hit on the counter-update edge -> hit_count=0, run_len=0, sticky_hit=0. The following hit -> hit_count=1.
